// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand-conditioning modes and width helpers.
package alu_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_ABS  = 2'b11
    } mode_e;

    localparam int MAX_WIDTH = 64;

    // Most-negative two's-complement value of a given width, zero-extended to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int width);
        logic [MAX_WIDTH-1:0] one;
        one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
        return one << (width - 1);
    endfunction

endpackage

// File: rtl/operand_cond_pipe_if.sv
// Operand-in / result-out handshake bundle for the operand conditioner.
interface operand_cond_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_sign;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_sign, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_sign, out_ovf
    );
endinterface

// File: rtl/cond_inv_n.sv
// Conditional bitwise inverter: out = in XOR {WIDTH{inv_en}}; purely combinational.
module cond_inv_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in_dat,
    input  logic             inv_en,
    output logic [WIDTH-1:0] out_dat
);
    assign out_dat = in_dat ^ {WIDTH{inv_en}};
endmodule

// File: rtl/operand_cond_pipe.sv
// Two-stage B-operand conditioner (pass/inv/neg/abs) with zero/sign/overflow flags.
// Latency 2 cycles, 1 op/cycle; stalls hold output stable, flush empties both stages.
module operand_cond_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    operand_cond_pipe_if.slave io
);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s1_cin_q,   s1_cin_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic             s2_zero_q,  s2_zero_d;
    logic             s2_sign_q,  s2_sign_d;
    logic             s2_ovf_q,   s2_ovf_d;

    mode_e            in_mode;
    logic             neg_en, inv_en;
    logic             in_ready, accept, s2_free, s1_adv;
    logic [WIDTH-1:0] inv_dat, sum;

    always_comb begin
        in_mode = mode_e'(io.in_mode);
        neg_en  = (in_mode == MODE_NEG) | ((in_mode == MODE_ABS) & io.in_data[WIDTH-1]);
        inv_en  = (in_mode == MODE_INV) | neg_en;
    end

    cond_inv_n #(.WIDTH(WIDTH)) u_inv (
        .in_dat  (io.in_data),
        .inv_en  (inv_en),
        .out_dat (inv_dat)
    );

    assign s2_free  = !s2_valid_q | io.out_ready;
    assign s1_adv   = s1_valid_q & s2_free;
    assign in_ready = !flush & (!s1_valid_q | s2_free);
    assign accept   = io.in_valid & in_ready;

    // Negation completes here: ~x + 1, carry-out dropped.
    assign sum = s1_data_q + {{(WIDTH-1){1'b0}}, s1_cin_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_cin_d   = s1_cin_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_zero_d  = s2_zero_q;
        s2_sign_d  = s2_sign_q;
        s2_ovf_d   = s2_ovf_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = inv_dat;
            s1_cin_d   = neg_en;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = sum;
            s2_zero_d  = (sum == '0);
            s2_sign_d  = sum[WIDTH-1];
            s2_ovf_d   = s1_cin_q & (sum == MOST_NEG);
        end else if (io.out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_zero_q  <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_zero_q  <= s2_zero_d;
            s2_sign_q  <= s2_sign_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = s2_valid_q;
    assign io.out_data  = s2_data_q;
    assign io.out_zero  = s2_zero_q;
    assign io.out_sign  = s2_sign_q;
    assign io.out_ovf   = s2_ovf_q;

endmodule

// File: doc/operand_cond_pipe.md
Name: operand_cond_pipe

Overview:
- Parametrised, two-stage pipelined operand conditioner for the ALU's B-operand path.
- It generalises the fixed 16-bit XOR-with-flag inverter to any WIDTH and adds four modes: pass, one's complement, two's-complement negate and absolute value.
- It produces result flags and uses a valid/ready handshake with backpressure and flush.
- It sits between decode/forwarding and the ALU adder, so subtraction and absolute-value operations no longer need a separate carry-in path.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drops all in-flight operands at the next edge.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand, two's complement.
- in_mode  input  2  00 PASS, 01 INV, 10 NEG, 11 ABS.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  conditioned result.
- out_zero  output  1  out_data == 0.
- out_sign  output  1  out_data[WIDTH-1].
- out_ovf  output  1  NEG or ABS of the most-negative value (1 followed by WIDTH-1 zeros).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. On an edge with rst=1:
  - s1_valid and s2_valid clear to 0.
  - out_data, out_zero, out_sign and out_ovf clear to 0.
  - out_valid is 0 from the first cycle after that edge.
- Stage 1 (on accept, i.e. in_valid & in_ready):
  - neg_en = (mode==NEG) | (mode==ABS & in_data[WIDTH-1]).
  - inv_en = (mode==INV) | neg_en.
  - Register s1_data = in_data XOR {WIDTH{inv_en}}, s1_cin = neg_en, s1_valid = 1.
- Stage 2 (on s1 advance):
  - s2_data = s1_data + s1_cin, truncated to WIDTH bits, with the carry-out discarded.
  - Register s2_data and the flags computed from it:
    - zero = (s2_data == 0).
    - sign = MSB of s2_data.
    - ovf = s1_cin & (s2_data == most-negative value).
- Outputs: out_data and the flags are driven directly from the stage-2 registers. out_valid = s2_valid.
- Latency and throughput:
  - Latency is 2 cycles from the accept edge to out_valid=1, when there is no backpressure.
  - Throughput is 1 operand per cycle.
- Handshake:
  - s2_free = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !flush & (!s1_valid | s2_free).
  - Stage 2 loads when s1_adv. Stage 2 clears when out_ready & !s1_adv.
  - Stage 1 loads on accept. Stage 1 clears when s1_adv & !accept.
- Stall: while out_valid & !out_ready, out_data and all flags hold stable.
- Full pipeline: with both stages full and out_ready=0, in_ready=0, and no operand is lost or reordered.
- Simultaneous events:
  - Accept and s1_adv in the same cycle: stage 1 reloads and stage 2 takes the old stage-1 content.
  - Output pop and s1_adv in the same cycle: stage 2 reloads with no bubble.
- Flush:
  - Flush has priority over accept and advance: at the edge, s1_valid = s2_valid = 0.
  - in_ready=0 during the flush cycle, so no operand is accepted.
  - Data registers may keep stale values.
- rst outranks flush. Reset mid-stream discards all in-flight operands.
- Mode results:
  - PASS: unchanged, ovf=0.
  - INV: bitwise NOT, ovf=0.
  - NEG of 0: result 0, zero=1, ovf=0.
  - NEG or ABS of the most-negative value: result is the most-negative value, ovf=1, sign=1.
  - ABS of a non-negative value: unchanged.
- Per-operand mode: in_mode is sampled with in_data on accept. Mode may change every cycle.

Decomposition:
- Shared package alu_pkg:
  - Mode constants MODE_PASS=2'b00, MODE_INV=2'b01, MODE_NEG=2'b10, MODE_ABS=2'b11.
  - Helper constant function for the most-negative value of a given WIDTH.
- Sub-module cond_inv_n (parameter WIDTH): combinational XOR of each bit of the operand with a single enable bit.
  - Instantiated in stage 1.
  - Reusable by the ALU subtract path.
- The incrementer and the flag logic stay inline in stage 2.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0x0000, all flags 0, no operand accepted while rst=1.
- PASS/INV with WIDTH=16 and out_ready=1:
  - PASS 0x1234 -> out 0x1234 exactly 2 cycles after accept.
  - INV 0x00FF -> 0xFF00, sign=1, ovf=0.
- NEG with WIDTH=16, back-to-back on consecutive cycles:
  - 0x0001 -> 0xFFFF, sign=1.
  - 0x0000 -> 0x0000, zero=1.
  - 0x8000 -> 0x8000, ovf=1.
  - Results appear on consecutive cycles.
- ABS: 0xFFFB -> 0x0005; 0x0007 -> 0x0007; 0x8000 -> 0x8000 with ovf=1.
- Backpressure: stream A=0x0011, B=0x0022, C=0x0033 in PASS mode with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts.
  - out_data holds 0x0011 stably during the stall.
  - After out_ready=1, the outputs are 0x0011, 0x0022, 0x0033 in order with no loss.
- Flush: assert flush with both stages full and in_valid=1 -> in_ready=0 that cycle, out_valid=0 the next cycle, and the operand offered during the flush never appears.
- Parameter sweep: WIDTH=8, NEG 0x80 -> 0x80 with ovf=1; ABS 0xFE -> 0x02.
